// File: rtl/bw_logic_pipe.sv
// Pipelined two-operand bitwise logic unit with valid/ready flow control,
// zero/all-ones flags and a retired-operation counter.

module bw_logic_stage #(
  parameter int W = 34
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         adv,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         vld,
  output logic [W-1:0] data
);

  // Payload only loads when a live item moves in, so a stalled stage holds still.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else begin
      if (flush)    vld <= 1'b0;
      else if (adv) vld <= in_vld;
      if (!flush && adv && in_vld) data <= in_data;
    end
  end

endmodule

module bw_logic_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ctrl_op,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             out_zero,
  output logic             out_allones,
  output logic [15:0]      retired_count
);

  localparam int PW = WIDTH + 2;

  logic [WIDTH-1:0]             fn_res;
  logic [PW-1:0]                fn_pkt;
  logic                         acc;
  logic [STAGES-1:0]            stg_vld;
  logic [STAGES-1:0][PW-1:0]    stg_dat;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][PW-1:0]      dat_pipe;
  logic [STAGES-1:0]            adv;

  always_comb begin
    fn_res = '0;
    case (ctrl_op)
      3'b000:  fn_res = ~data_operandA;
      3'b001:  fn_res = data_operandA & data_operandB;
      3'b010:  fn_res = data_operandA | data_operandB;
      3'b011:  fn_res = data_operandA ^ data_operandB;
      3'b100:  fn_res = ~(data_operandA & data_operandB);
      3'b101:  fn_res = ~(data_operandA | data_operandB);
      3'b110:  fn_res = ~(data_operandA ^ data_operandB);
      default: fn_res = data_operandA & ~data_operandB;
    endcase
  end

  assign fn_pkt = {&fn_res, ~|fn_res, fn_res};

  // A stage moves when it or anything downstream of it has a hole, or the
  // consumer takes the head; this is what lets bubbles collapse.
  always_comb begin
    logic go;
    go  = out_ready;
    adv = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      go     = go || !stg_vld[i];
      adv[i] = go;
    end
  end

  assign in_ready = reset_n && !flush && adv[0];
  assign acc      = in_valid && in_ready;
  assign vld_pipe = {stg_vld, acc};
  assign dat_pipe = {stg_dat, fn_pkt};

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    bw_logic_stage #(.W(PW)) u_stg (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (flush),
      .adv     (adv[i]),
      .in_vld  (vld_pipe[i]),
      .in_data (dat_pipe[i]),
      .vld     (stg_vld[i]),
      .data    (stg_dat[i])
    );
  end

  assign out_valid                             = stg_vld[STAGES-1];
  assign {out_allones, out_zero, data_result}  = stg_dat[STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    retired_count <= '0;
    else if (out_valid && out_ready) retired_count <= retired_count + 16'd1;
  end

endmodule

// File: tb/tb_bw_logic_pipe.sv
// Bench for bw_logic_pipe: three parameterisations checked against a
// queue-based reference model under random and directed stimulus.

module tb_bw_logic_pipe;

  logic        clock, reset_n, flush;
  logic        iv [3];
  logic [2:0]  op [3];
  logic [63:0] a [3], b [3];
  logic        orr [3];
  logic        ir [3], ov [3], zf [3], af [3];
  logic [15:0] rc [3];
  logic [31:0] r0;
  logic [7:0]  r1;
  logic [63:0] r2;
  logic [63:0] res [3];

  assign res[0] = {32'd0, r0};
  assign res[1] = {56'd0, r1};
  assign res[2] = r2;

  bw_logic_pipe #(.WIDTH(32), .STAGES(2)) u_w32 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(iv[0]), .in_ready(ir[0]), .ctrl_op(op[0]),
    .data_operandA(a[0][31:0]), .data_operandB(b[0][31:0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .data_result(r0),
    .out_zero(zf[0]), .out_allones(af[0]), .retired_count(rc[0]));

  bw_logic_pipe #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(iv[1]), .in_ready(ir[1]), .ctrl_op(op[1]),
    .data_operandA(a[1][7:0]), .data_operandB(b[1][7:0]),
    .out_valid(ov[1]), .out_ready(orr[1]), .data_result(r1),
    .out_zero(zf[1]), .out_allones(af[1]), .retired_count(rc[1]));

  bw_logic_pipe #(.WIDTH(64), .STAGES(4)) u_w64 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(iv[2]), .in_ready(ir[2]), .ctrl_op(op[2]),
    .data_operandA(a[2]), .data_operandB(b[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .data_result(r2),
    .out_zero(zf[2]), .out_allones(af[2]), .retired_count(rc[2]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int          n_cmp, n_bad;
  logic [65:0] q [3][$];
  logic [15:0] cnt [3];

  function automatic int stg(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic int wid(input int k);
    return (k == 0) ? 32 : ((k == 1) ? 8 : 64);
  endfunction

  // Expected packet {allones, zero, result} straight from the function table.
  function automatic logic [65:0] pkt(input logic [2:0] o, input logic [63:0] x,
                                      input logic [63:0] y, input int w);
    logic [63:0] r, m;
    case (o)
      3'd0: r = ~x;
      3'd1: r = x & y;
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: r = ~(x & y);
      3'd5: r = ~(x | y);
      3'd6: r = ~(x ^ y);
      default: r = x & ~y;
    endcase
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    r = r & m;
    return {r == m, r == 64'd0, r};
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Per-cycle scoreboard: occupancy-based ready, in-order results, retire count.
  task automatic sb_step(input int k);
    logic        rdy;
    logic [65:0] e;
    if (!reset_n) begin
      q[k].delete();
      cnt[k] = '0;
      return;
    end
    rdy = !flush && (q[k].size() < stg(k) || orr[k]);
    chk("in_ready", k, 64'(ir[k]), 64'(rdy));
    chk("retired", k, 64'(rc[k]), 64'(cnt[k]));
    if (ov[k]) begin
      if (q[k].size() == 0) chk("unexpected_valid", k, 64'(ov[k]), 64'd0);
      else begin
        e = q[k][0];
        chk("result", k, res[k], e[63:0]);
        chk("zero", k, 64'(zf[k]), 64'(e[64]));
        chk("allones", k, 64'(af[k]), 64'(e[65]));
        if (orr[k]) begin
          void'(q[k].pop_front());
          cnt[k] = cnt[k] + 16'd1;
        end
      end
    end
    if (flush) q[k].delete();
    else if (iv[k] && rdy) q[k].push_back(pkt(op[k], a[k], b[k], wid(k)));
  endtask

  task automatic rnd_op(input int k);
    op[k] = 3'($urandom);
    a[k]  = {$urandom, $urandom};
    b[k]  = {$urandom, $urandom};
  endtask

  task automatic drain(input int k, input string tag);
    iv[k] = 1'b0; flush = 1'b0; orr[k] = 1'b1;
    for (int i = 0; i < 30 && q[k].size() != 0; i++) tick();
    chk(tag, k, 64'(q[k].size()), 64'd0);
  endtask

  task automatic send_one(input int k, input logic [2:0] o, input logic [63:0] x,
                          input logic [63:0] y);
    tick();
    iv[k] = 1'b1; op[k] = o; a[k] = x; b[k] = y; orr[k] = 1'b1;
    tick();
    iv[k] = 1'b0;
    for (int e = 0; e < stg(k); e++) begin
      @(negedge clock);
      chk("latency", k, 64'(ov[k]), 64'(e == stg(k) - 1));
    end
  endtask

  task automatic run_funcs(input int k);
    logic [2:0]  t_op [4] = '{3'd0, 3'd0, 3'd3, 3'd7};
    logic [31:0] t_a  [4] = '{32'h0000FFFF, 32'h0, 32'hAAAAAAAA, 32'hF0F0F0F0};
    logic [31:0] t_b  [4] = '{32'h12345678, 32'h9ABCDEF0, 32'hAAAAAAAA, 32'hFF00FF00};
    logic [31:0] t_e  [4] = '{32'hFFFF0000, 32'hFFFFFFFF, 32'h0, 32'h00F000F0};
    logic        t_z  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        t_o  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send_one(k, t_op[i], {32'd0, t_a[i]}, {32'd0, t_b[i]});
      if (k == 0) begin
        chk("fn_const", k, res[0], {32'd0, t_e[i]});
        chk("fn_zero", k, 64'(zf[0]), 64'(t_z[i]));
        chk("fn_ones", k, 64'(af[0]), 64'(t_o[i]));
      end
    end
  endtask

  task automatic stream8(input int k);
    int          run, best;
    logic [15:0] want;
    tick();
    orr[k] = 1'b1; want = cnt[k] + 16'd8; run = 0; best = 0;
    for (int i = 0; i < 8 + stg(k) + 3; i++) begin
      iv[k] = (i < 8);
      rnd_op(k);
      @(negedge clock);
      run  = ov[k] ? run + 1 : 0;
      best = (run > best) ? run : best;
      tick();
    end
    iv[k] = 1'b0;
    chk("stream_run", k, 64'(best), 64'd8);
    chk("stream_retired", k, 64'(rc[k]), 64'(want));
  endtask

  task automatic backpressure(input int k);
    int          n;
    logic [15:0] want;
    tick();
    orr[k] = 1'b0; want = cnt[k] + 16'(stg(k)); n = 0;
    for (int i = 0; i < 5; i++) begin
      iv[k] = 1'b1;
      rnd_op(k);
      @(negedge clock);
      if (ir[k]) n++;
      tick();
    end
    iv[k] = 1'b0;
    chk("bp_accepts", k, 64'(n), 64'(stg(k)));
    drain(k, "bp_drain");
    chk("bp_retired", k, 64'(rc[k]), 64'(want));
  endtask

  task automatic flush_test(input int k);
    logic [15:0] base;
    tick();
    orr[k] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[k] = 1'b1;
      rnd_op(k);
      tick();
    end
    iv[k] = 1'b0; flush = 1'b1; base = cnt[k];
    tick();
    flush = 1'b0;
    @(negedge clock);
    chk("flush_valid", k, 64'(ov[k]), 64'd0);
    chk("flush_retired", k, 64'(rc[k]), 64'(base));
    send_one(k, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic rand_phase(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      iv[k]  = ($urandom_range(0, 3) != 0);
      orr[k] = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      rnd_op(k);
    end
    tick();
    drain(k, "rand_drain");
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b1; orr[k] = 1'b1; cnt[k] = '0;
      rnd_op(k);
    end
    fork
      forever begin
        @(negedge clock);
        for (int k = 0; k < 3; k++) sb_step(k);
      end
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 64'(ov[k]), 64'd0);
      chk("rst_result", k, res[k], 64'd0);
      chk("rst_zero", k, 64'(zf[k]), 64'd0);
      chk("rst_ones", k, 64'(af[k]), 64'd0);
      chk("rst_count", k, 64'(rc[k]), 64'd0);
      chk("rst_ready", k, 64'(ir[k]), 64'd0);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk("rel_ready", k, 64'(ir[k]), 64'd1);
      chk("rel_valid", k, 64'(ov[k]), 64'd0);
    end

    for (int k = 0; k < 3; k++) begin
      run_funcs(k);
      stream8(k);
      backpressure(k);
      flush_test(k);
      rand_phase(k, 300);
    end

    // Asynchronous reset with results in flight, checked before any edge.
    tick();
    orr[0] = 1'b0; iv[0] = 1'b1;
    rnd_op(0);
    tick();
    rnd_op(0);
    tick();
    iv[0] = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 0, 64'(ov[0]), 64'd0);
    chk("arst_result", 0, res[0], 64'd0);
    chk("arst_count", 0, 64'(rc[0]), 64'd0);
    chk("arst_ready", 0, 64'(ir[0]), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    send_one(0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});

    // Exactly 65536 handshakes on the single-stage unit wrap the counter.
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    orr[1] = 1'b1; iv[1] = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      rnd_op(1);
      tick();
    end
    iv[1] = 1'b0;
    tick();
    tick();
    chk("wrap", 1, 64'(rc[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bw_logic_pipe.md
# bw_logic_pipe

Parametrised, pipelined bitwise logic unit for the processor ALU. It extends the single-function 32-bit inverter to a configurable datapath width, eight selectable two-operand logic functions and a configurable number of register stages. It adds valid/ready flow control, result flags and a retired-operation counter. It sits between the ALU operand latch and the ALU result mux, so logic ops can be retimed without touching the adder or shifter paths.

## Interface
- WIDTH, 32, datapath width in bits; legal range 1..64.
- STAGES, 2, number of register stages; legal range 1..4.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept this cycle.
- ctrl_op  input  3  function select.
- data_operandA  input  WIDTH  first operand.
- data_operandB  input  WIDTH  second operand; ignored for NOT.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- data_result  output  WIDTH  logic result.
- out_zero  output  1  data_result is all zeros.
- out_allones  output  1  data_result is all ones.
- retired_count  output  16  count of completed output handshakes.

## Operation
- ctrl_op encoding: 000 ~A; 001 A&B; 010 A|B; 011 A^B; 100 ~(A&B); 101 ~(A|B); 110 ~(A^B); 111 A&~B.
- The function and both flags are computed combinationally at the input. They are captured into stage 0 on acceptance. Stages 1..STAGES-1 carry result, flags and a valid bit unchanged.
- Acceptance occurs when in_valid && in_ready on a rising edge.
- Each stage advances when it is empty or when its successor advances. The last stage advances on out_ready.
- in_ready = reset_n && !flush && (stage0 empty || stage0 advancing). Bubbles collapse, so a full pipeline under out_ready=1 sustains one op per cycle.
- When out_valid=1 and out_ready=0, data_result, out_zero and out_allones hold stable until the handshake completes.
- flush=1 clears every stage valid bit at the next edge. Data registers are not cleared. Nothing is accepted in a flush cycle. An output handshake occurring in the flush cycle still completes and is counted.
- retired_count increments by 1 on each out_valid && out_ready. It wraps 0xFFFF -> 0x0000. It is cleared only by reset; flush does not clear it.
- Ordering: results leave in acceptance order, with no loss and no duplication.

## Timing
- Latency: a result accepted at edge N is out_valid after edge N+STAGES-1, visible during cycle N+STAGES-1 (STAGES=1: visible in the cycle after acceptance). This holds when no downstream stall exists.
- Throughput: 1 op/cycle. Capacity: STAGES results in flight.
- Reset (reset_n low, asynchronous):
  - All valid bits, data registers and flags go to 0.
  - out_valid=0, data_result=0, out_zero=0, out_allones=0, retired_count=0.
  - in_ready=0 while reset_n is low; in_ready=1 in the first cycle after release if flush=0.
- Reset mid-operation discards all in-flight results immediately, without waiting for a clock edge.
- Simultaneous flush and acceptance: in_ready is 0, so no acceptance occurs.
- Simultaneous output handshake and input acceptance on a full pipeline: both occur in the same cycle, and occupancy is unchanged.

## Test plan
- Reset: hold reset_n low for 3 cycles with in_valid=1 -> all outputs 0 and in_ready=0. After release, in_ready=1 and out_valid=0.
- Functions (WIDTH=32, STAGES=2, out_ready=1):
  - op 000, A=0x0000FFFF -> 0xFFFF0000, flags 0/0.
  - op 000, A=0 -> 0xFFFFFFFF, out_allones=1.
  - op 011, A=B=0xAAAAAAAA -> 0, out_zero=1.
  - op 111, A=0xF0F0F0F0, B=0xFF00FF00 -> 0x00F000F0.
  - Each result appears 1 cycle after acceptance.
- Streaming: 8 back-to-back mixed ops with out_ready=1 -> 8 consecutive out_valid cycles, in order; retired_count=8.
- Backpressure: stream with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, head result held stable. Release out_ready -> all results delivered once, in order.
- Flush: 2 ops in flight, pulse flush -> out_valid=0 next cycle and retired_count unchanged. The following op returns its correct result with normal latency.
- Wrap and parameters:
  - Force 65536 handshakes -> retired_count=0x0000.
  - Rerun the function and backpressure scenarios with WIDTH=8/STAGES=1 and WIDTH=64/STAGES=4 -> latencies of 1 edge and 4 edges respectively.
